// File: rtl/add_1bit.sv
// add_1bit: gate-level 1-bit full adder cell with registered sum/carry.
// Used as a building block in the multiplier bit-slice columns (sum feeds
// the next cell's a, cOut feeds the next cell's cIn).
// Optional feature macro: ADD_1BIT_PG_EN adds registered propagate (pOut)
// and generate (gOut) outputs for carry-lookahead use.
`timescale 1ns/1ps

module add_1bit #(
  parameter int GATE_DELAY = 20
) (
  input  logic clk,
  input  logic rst_n,
  output logic sum,
  output logic cOut,
  input  logic a,
  input  logic b,
  input  logic cIn
`ifdef ADD_1BIT_PG_EN
  ,
  output logic pOut,
  output logic gOut
`endif
);

  // Combinational core nets; worst-case settle is three gate delays
  // (xor -> and -> or), so the clock period must exceed 3*GATE_DELAY.
  wire x1;
  wire s;
  wire g;
  wire p;
  wire c;

  xor #(GATE_DELAY) uXorAb  (x1, a, b);
  xor #(GATE_DELAY) uXorSum (s, x1, cIn);
  and #(GATE_DELAY) uAndGen (g, a, b);
  and #(GATE_DELAY) uAndPro (p, x1, cIn);
  or  #(GATE_DELAY) uOrCar  (c, g, p);

  // Register the core result once per cycle; reset discards any in-flight value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= 1'b0;
      cOut <= 1'b0;
    end else begin
      sum  <= s;
      cOut <= c;
    end
  end

`ifdef ADD_1BIT_PG_EN
  // Register propagate/generate alongside sum/carry so they share the same latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pOut <= 1'b0;
      gOut <= 1'b0;
    end else begin
      pOut <= x1;
      gOut <= g;
    end
  end
`endif

endmodule

// File: tb/tb_add_1bit.sv
// tb_add_1bit: self-checking bench for add_1bit. Expected values come from
// integer addition of the operand bits (a+b+cIn = {cOut,sum}).
`timescale 1ns/1ps

module tb_add_1bit;

  logic clk;
  logic rst_n;
  logic a, b, cIn;
  logic sum, cOut;

  // Three-cell column: sum -> next a, cOut -> next cIn.
  logic ca, cc, cb0, cb1, cb2;
  logic s0, s1, s2, co0, co1, co2;

  int checks   = 0;
  int failures = 0;

`ifdef ADD_1BIT_PG_EN
  logic pOut, gOut;
  logic p0, g0, p1, g1, p2, g2;
`endif

  add_1bit #(.GATE_DELAY(20)) dut (
    .clk(clk), .rst_n(rst_n), .sum(sum), .cOut(cOut), .a(a), .b(b), .cIn(cIn)
`ifdef ADD_1BIT_PG_EN
    , .pOut(pOut), .gOut(gOut)
`endif
  );

  add_1bit #(.GATE_DELAY(20)) cell0 (
    .clk(clk), .rst_n(rst_n), .sum(s0), .cOut(co0), .a(ca), .b(cb0), .cIn(cc)
`ifdef ADD_1BIT_PG_EN
    , .pOut(p0), .gOut(g0)
`endif
  );

  add_1bit #(.GATE_DELAY(20)) cell1 (
    .clk(clk), .rst_n(rst_n), .sum(s1), .cOut(co1), .a(s0), .b(cb1), .cIn(co0)
`ifdef ADD_1BIT_PG_EN
    , .pOut(p1), .gOut(g1)
`endif
  );

  add_1bit #(.GATE_DELAY(20)) cell2 (
    .clk(clk), .rst_n(rst_n), .sum(s2), .cOut(co2), .a(s1), .b(cb2), .cIn(co1)
`ifdef ADD_1BIT_PG_EN
    , .pOut(p2), .gOut(g2)
`endif
  );

  // 200 ns period leaves ample margin over the 60 ns core settle time.
  initial clk = 1'b0;
  always #100 clk = ~clk;

  // Reference: {carry,sum} of a full adder is the 2-bit integer a+b+cIn.
  function automatic logic [1:0] refAdd(input logic ra, input logic rb, input logic rc);
    int total;
    total = int'(ra) + int'(rb) + int'(rc);
    return total[1:0];
  endfunction

  // Drive on the falling edge, advance one rising edge, sample 1 ns later.
  task automatic stepCycle(input logic r, input logic ia, input logic ib, input logic ic);
    @(negedge clk);
    rst_n = r; a = ia; b = ib; cIn = ic;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      stepCycle(1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({cOut, sum} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_hold cycle=%0d got cOut,sum=%b%b expected 00", i, cOut, sum);
      end
    end
  endtask

  task automatic test_truth_sweep;
    logic [2:0] v;
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      exp = refAdd(v[2], v[1], v[0]);
      stepCycle(1'b1, v[2], v[1], v[0]);
      checks++;
      if ({cOut, sum} !== exp) begin
        failures++;
        $display("[TB] FAIL truth_row abc=%b got cOut,sum=%b%b expected %b", v, cOut, sum, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    stepCycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (sum !== 1'b0 || cOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_first got sum,cOut=%b%b expected 01", sum, cOut);
    end
    stepCycle(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (sum !== 1'b1 || cOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_second got sum,cOut=%b%b expected 10", sum, cOut);
    end
  endtask

  task automatic test_mid_reset;
    stepCycle(1'b1, 1'b0, 1'b1, 1'b0);
    stepCycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({cOut, sum} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL mid_reset got cOut,sum=%b%b expected 00", cOut, sum);
    end
    stepCycle(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (sum !== 1'b1 || cOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL post_reset got sum,cOut=%b%b expected 11", sum, cOut);
    end
  endtask

  // Hold column operands steady for four edges so the three-stage chain fills.
  task automatic runChain(input logic ia, input logic ic, input logic [2:0] bv,
                          input string tag);
    int t0, t1, t2;
    logic [2:0] expCarry;
    logic expOut;
    @(negedge clk);
    rst_n = 1'b1; ca = ia; cc = ic; cb0 = bv[0]; cb1 = bv[1]; cb2 = bv[2];
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    t0 = int'(ia) + int'(bv[0]) + int'(ic);
    t1 = (t0 % 2) + int'(bv[1]) + (t0 / 2);
    t2 = (t1 % 2) + int'(bv[2]) + (t1 / 2);
    expOut   = (t2 % 2) == 1;
    expCarry = {(t2 / 2) == 1, (t1 / 2) == 1, (t0 / 2) == 1};
    checks++;
    if (s2 !== expOut || {co2, co1, co0} !== expCarry) begin
      failures++;
      $display("[TB] FAIL chain_%s got out=%b carries=%b expected out=%b carries=%b",
               tag, s2, {co2, co1, co0}, expOut, expCarry);
    end
  endtask

  task automatic test_chain;
    // Column 0 of A=1, B=2: only A[0]=1 contributes, so out=1 and no carries.
    runChain(1'b1, 1'b0, 3'b000, "slice_a1_b2");
    for (int i = 0; i < 4; i++)
      runChain(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)), "random");
  endtask

  task automatic test_random;
    logic r, ia, ib, ic;
    logic [1:0] exp;
    for (int i = 0; i < 40; i++) begin
      r  = ($urandom_range(0, 9) != 0);
      ia = 1'($urandom_range(0, 1));
      ib = 1'($urandom_range(0, 1));
      ic = 1'($urandom_range(0, 1));
      exp = r ? refAdd(ia, ib, ic) : 2'b00;
      stepCycle(r, ia, ib, ic);
      checks++;
      if ({cOut, sum} !== exp) begin
        failures++;
        $display("[TB] FAIL random i=%0d rst_n=%b abc=%b%b%b got %b%b expected %b",
                 i, r, ia, ib, ic, cOut, sum, exp);
      end
    end
  endtask

`ifdef ADD_1BIT_PG_EN
  task automatic test_pg;
    stepCycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (pOut !== 1'b1 || gOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pg_a1b0 got p,g=%b%b expected 10", pOut, gOut);
    end
    stepCycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (pOut !== 1'b0 || gOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pg_a1b1 got p,g=%b%b expected 01", pOut, gOut);
    end
    stepCycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (pOut !== 1'b0 || gOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pg_reset got p,g=%b%b expected 00", pOut, gOut);
    end
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    rst_n = 1'b0; a = 1'b0; b = 1'b0; cIn = 1'b0;
    ca = 1'b0; cc = 1'b0; cb0 = 1'b0; cb1 = 1'b0; cb2 = 1'b0;
    test_reset();
    test_truth_sweep();
    test_back_to_back();
    test_mid_reset();
    test_chain();
    test_random();
`ifdef ADD_1BIT_PG_EN
    test_pg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
